// File: rtl/display_capture_if.sv
// display_capture_if -- scanned display bus shared by the multiplexed
// display driver and the display_capture monitor.
//   digit_select : 4-bit one-hot digit enable (polarity set by the capture side)
//   digit_value  : hex nibble of the currently selected digit
//   count        : last completely captured 16-bit value
//   valid        : one-cycle pulse when count is updated
//   frame_err    : one-cycle pulse on a scan protocol violation
//   digits_seen  : digits accepted so far in the current frame
// master = driver side, slave = capture side.
interface display_capture_if;
   logic [3:0]  digit_select;
   logic [3:0]  digit_value;
   logic [15:0] count;
   logic        valid;
   logic        frame_err;
   logic [3:0]  digits_seen;

   modport master (
      output digit_select, digit_value,
      input  count, valid, frame_err, digits_seen
   );

   modport slave (
      input  digit_select, digit_value,
      output count, valid, frame_err, digits_seen
   );
endinterface

// File: rtl/display_capture.sv
// display_capture -- watches a scanned four-digit display bus, rebuilds the
// 16-bit value being shown and publishes it once per complete in-order frame.
//   inc   : clock, all state updates on its rising edge
//   reset : asynchronous active-low reset
//   bus   : display_capture_if.slave (digit_select/digit_value in,
//           count/valid/frame_err/digits_seen out)
// Parameters:
//   ACTIVE_LOW    : 1 = select is one-hot active-low, 0 = active-high
//   STABLE_CYCLES : 1..15 unchanged samples needed before a digit is accepted
module display_capture #(
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned STABLE_CYCLES = 1
) (
   input  logic             inc,
   input  logic             reset,
   display_capture_if.slave bus
);

   localparam logic [3:0] BLANK    = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [4:0] STAB_TGT = 5'(STABLE_CYCLES);
   // Counter saturates one above the largest legal target so an acceptance
   // fires only once per continuous hold.
   localparam logic [4:0] STAB_MAX = 5'd16;

   typedef enum logic {IDLE, CAPTURE} state_t;

   // input stage
   logic [3:0]  sel_q;
   logic [3:0]  val_q;
   logic [4:0]  stab_q, stab_d;

   // decode
   logic [3:0]  norm;
   logic        is_blank;
   logic        is_multi;
   logic [1:0]  idx;
   logic        accept;
   logic        multi_new;

   // frame state
   state_t      state_q;
   logic [1:0]  expect_q;
   logic [11:0] nib_q;       // {nib2, nib1, nib0}, shifted in as digits arrive
   logic [15:0] count_q;
   logic        valid_q;
   logic        err_q;
   logic [3:0]  seen_q;

   // Stability counter tracks the hold length of the value being loaded into
   // sel_q, so stab_q always pairs with the current sel_q. Blanking holds it.
   always_comb begin
      stab_d = stab_q;
      if (bus.digit_select != sel_q) begin
         stab_d = 5'd1;
      end else if (sel_q != BLANK && stab_q != STAB_MAX) begin
         stab_d = stab_q + 5'd1;
      end
   end

   always_ff @(posedge inc or negedge reset) begin
      if (!reset) begin
         sel_q  <= BLANK;
         val_q  <= '0;
         stab_q <= '0;
      end else begin
         sel_q  <= bus.digit_select;
         val_q  <= bus.digit_value;
         stab_q <= stab_d;
      end
   end

   always_comb begin
      norm     = ACTIVE_LOW ? ~sel_q : sel_q;
      is_blank = (norm == '0);
      is_multi = !is_blank && ((norm & (norm - 4'd1)) != '0);
      idx      = 2'd0;
      unique case (norm)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      accept    = !is_blank && !is_multi && (stab_q == STAB_TGT);
      // A multi-hot value errors on its first sample, whatever the stability target.
      multi_new = is_multi && (stab_q == 5'd1);
   end

   always_ff @(posedge inc or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         expect_q <= '0;
         nib_q    <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         seen_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (multi_new) begin
            err_q   <= 1'b1;
            seen_q  <= '0;
            state_q <= IDLE;
         end else if (accept) begin
            unique case (state_q)
               IDLE: begin
                  if (idx == 2'd0) begin
                     nib_q    <= {val_q, 8'h00};
                     seen_q   <= 4'b0001;
                     expect_q <= 2'd1;
                     state_q  <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  if (idx == 2'd0) begin
                     // scan restarted early: flag it and begin a new frame
                     err_q    <= 1'b1;
                     nib_q    <= {val_q, 8'h00};
                     seen_q   <= 4'b0001;
                     expect_q <= 2'd1;
                  end else if (idx == expect_q) begin
                     if (idx == 2'd3) begin
                        count_q <= {val_q, nib_q};
                        valid_q <= 1'b1;
                        seen_q  <= '0;
                        state_q <= IDLE;
                     end else begin
                        nib_q    <= {val_q, nib_q[11:4]};
                        seen_q   <= seen_q | norm;
                        expect_q <= expect_q + 2'd1;
                     end
                  end else begin
                     err_q   <= 1'b1;
                     seen_q  <= '0;
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.count       = count_q;
   assign bus.valid       = valid_q;
   assign bus.frame_err   = err_q;
   assign bus.digits_seen = seen_q;

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture -- self-checking bench for display_capture.
// Two instances: dut1 (STABLE_CYCLES = 1) and dut3 (STABLE_CYCLES = 3), both
// active-low. Expected frame values are queued when a frame is driven and
// compared when the matching valid pulse appears.
`timescale 1ns/1ps
module tb_display_capture;

   logic clk;
   logic rst_n;

   display_capture_if bus1 ();
   display_capture_if bus3 ();

   display_capture #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(1)) dut1 (
      .inc   (clk),
      .reset (rst_n),
      .bus   (bus1)
   );

   display_capture #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(3)) dut3 (
      .inc   (clk),
      .reset (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_err = 0;
   int unsigned n_chk = 0;
   int unsigned err1  = 0;
   int unsigned err3  = 0;
   logic [15:0] q1[$];
   logic [15:0] q3[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drv(input int unsigned d, input logic [3:0] sel, input logic [3:0] val);
      if (d == 1) begin
         bus1.digit_select = sel;
         bus1.digit_value  = val;
      end else begin
         bus3.digit_select = sel;
         bus3.digit_value  = val;
      end
   endtask

   function automatic logic [3:0] dsel(input int unsigned i);
      logic [3:0] s;
      s    = 4'hF;
      s[i] = 1'b0;
      return s;
   endfunction

   task automatic send_frame(input int unsigned d, input logic [15:0] v,
                             input int unsigned hold, input int unsigned gap);
      for (int unsigned i = 0; i < 4; i++) begin
         drv(d, dsel(i), v[4*i +: 4]);
         step(hold);
         if (gap != 0) begin
            drv(d, 4'hF, 4'h0);
            step(gap);
         end
      end
   endtask

   // scoreboard / event monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus1.valid) begin
            if (q1.size() == 0) check_eq("spurious_valid1", {31'b0, bus1.valid}, 32'd0);
            else                check_eq("count1", {16'b0, bus1.count}, {16'b0, q1.pop_front()});
         end
         if (bus3.valid) begin
            if (q3.size() == 0) check_eq("spurious_valid3", {31'b0, bus3.valid}, 32'd0);
            else                check_eq("count3", {16'b0, bus3.count}, {16'b0, q3.pop_front()});
         end
         if (bus1.frame_err) begin
            err1++;
            check_eq("excl1", {31'b0, bus1.valid}, 32'd0);
         end
         if (bus3.frame_err) begin
            err3++;
            check_eq("excl3", {31'b0, bus3.valid}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned e0;
      rst_n = 1'b0;
      drv(1, 4'hF, 4'h0);
      drv(3, 4'hF, 4'h0);
      step(3);
      check_eq("rst_count", {16'b0, bus1.count}, 32'd0);
      check_eq("rst_seen",  {28'b0, bus1.digits_seen}, 32'd0);
      rst_n = 1'b1;
      step(2);
      check_eq("post_rst_flags", {30'b0, bus1.valid, bus1.frame_err}, 32'd0);

      // nominal scan, 4 cycles per digit
      e0 = err1;
      drv(1, 4'b1110, 4'h3); step(4);
      check_eq("seen_d0", {28'b0, bus1.digits_seen}, 32'h1);
      drv(1, 4'b1101, 4'hC); step(4);
      check_eq("seen_d1", {28'b0, bus1.digits_seen}, 32'h3);
      drv(1, 4'b1011, 4'h5); step(4);
      check_eq("seen_d2", {28'b0, bus1.digits_seen}, 32'h7);
      q1.push_back(16'hA5C3);
      drv(1, 4'b0111, 4'hA); step(1);
      check_eq("valid_early", {31'b0, bus1.valid}, 32'd0);
      step(1);
      check_eq("valid_latency", {31'b0, bus1.valid}, 32'd1);
      check_eq("nominal_count", {16'b0, bus1.count}, 32'hA5C3);
      check_eq("seen_cleared", {28'b0, bus1.digits_seen}, 32'h0);
      step(1);
      check_eq("valid_width", {31'b0, bus1.valid}, 32'd0);
      step(1);

      // blanking between every digit
      q1.push_back(16'h1234);
      send_frame(1, 16'h1234, 3, 2);
      check_eq("blank_count", {16'b0, bus1.count}, 32'h1234);
      check_eq("blank_errs", err1 - e0, 32'd0);

      // digit 0 then digit 2
      e0 = err1;
      drv(1, dsel(0), 4'h8); step(3);
      drv(1, dsel(2), 4'h9); step(3);
      check_eq("skip_err", err1 - e0, 32'd1);
      check_eq("skip_seen", {28'b0, bus1.digits_seen}, 32'h0);
      check_eq("skip_count", {16'b0, bus1.count}, 32'h1234);
      drv(1, 4'hF, 4'h0); step(2);

      // multi-hot select
      e0 = err1;
      drv(1, 4'b1100, 4'h1); step(3);
      check_eq("multi_err", err1 - e0, 32'd1);
      drv(1, 4'hF, 4'h0); step(2);

      // 0, 1, 0, 1, 2, 3: restart mid-frame
      e0 = err1;
      drv(1, dsel(0), 4'hB); step(3);
      drv(1, dsel(1), 4'hD); step(3);
      q1.push_back(16'h9876);
      send_frame(1, 16'h9876, 3, 0);
      check_eq("restart_err", err1 - e0, 32'd1);
      check_eq("restart_drain", q1.size(), 32'd0);
      drv(1, 4'hF, 4'h0); step(2);

      // reset mid-frame
      drv(1, dsel(0), 4'h5); step(3);
      drv(1, dsel(1), 4'h6); step(3);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_count", {16'b0, bus1.count}, 32'd0);
      check_eq("async_rst_seen",  {28'b0, bus1.digits_seen}, 32'd0);
      drv(1, 4'hF, 4'h0);
      step(3);
      rst_n = 1'b1;
      step(1);
      check_eq("rel_outputs", {bus1.count, 10'b0, bus1.valid, bus1.frame_err, bus1.digits_seen}, 32'd0);
      e0 = err1;
      for (int unsigned i = 1; i < 4; i++) begin
         drv(1, dsel(i), 4'h7); step(3);
      end
      check_eq("partial_err", err1 - e0, 32'd0);
      check_eq("partial_count", {16'b0, bus1.count}, 32'd0);
      q1.push_back(16'h4321);
      send_frame(1, 16'h4321, 3, 0);
      check_eq("after_rst_count", {16'b0, bus1.count}, 32'h4321);

      // STABLE_CYCLES = 3: glitch and value change within a hold
      e0 = err3;
      drv(3, dsel(0), 4'h7); step(1);
      drv(3, dsel(1), 4'h1); step(1);
      drv(3, dsel(0), 4'h7); step(5);
      check_eq("glitch_seen", {28'b0, bus3.digits_seen}, 32'h1);
      q3.push_back(16'hE257);
      drv(3, dsel(1), 4'h5); step(3);
      drv(3, dsel(1), 4'hF); step(2);
      check_eq("hold_seen", {28'b0, bus3.digits_seen}, 32'h3);
      drv(3, dsel(2), 4'h2); step(4);
      drv(3, dsel(3), 4'hE); step(5);
      check_eq("stable3_drain", q3.size(), 32'd0);
      check_eq("stable3_errs", err3 - e0, 32'd0);
      drv(3, 4'hF, 4'h0);

      // continuous loopback, no gaps
      e0 = err1;
      for (int unsigned v = 0; v <= 16'h0100; v++) begin
         q1.push_back(16'(v));
         send_frame(1, 16'(v), 2, 0);
      end
      drv(1, 4'hF, 4'h0);
      step(5);
      check_eq("loop_errs", err1 - e0, 32'd0);
      check_eq("loop_drain", q1.size(), 32'd0);
      check_eq("loop_last", {16'b0, bus1.count}, 32'h0100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side counterpart of the four-digit multiplexed display driver. It watches the scanned digit_select / digit value bus, reconstructs the 16-bit value being displayed, and publishes it once per complete, in-order scan frame. It also flags protocol violations. It sits on the same bus as the driver and serves as an in-system monitor and as a loopback checker in benches.

## Interface
- ACTIVE_LOW, default 1: 1 = digit_select is one-hot active-low (1110 = digit 0); 0 = one-hot active-high (0001 = digit 0).
- STABLE_CYCLES, default 1, range 1..15: consecutive registered samples with an unchanged select required before a digit is accepted.

- inc  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- digit_select  in  4  scanned digit enable; bit i selects nibble i (digit 0 = count[3:0], digit 3 = count[15:12]).
- digit_value  in  4  hex value of the currently selected digit.
- count  out  16  last completely captured value.
- valid  out  1  one-cycle pulse when count is updated.
- frame_err  out  1  one-cycle pulse on a protocol violation.
- digits_seen  out  4  bit i set once digit i has been accepted in the current frame.

## Operation
- Inputs are registered once (sel_r, val_r); all decisions use the registered copies.
- Select decode after polarity normalisation:
  - one-hot: digit index 0..3.
  - all-off (blanking): ignored; state, stability counter and digits_seen hold.
  - multi-hot: violation.
- Stability: a counter resets to 1 when sel_r changes and increments (saturating) while sel_r is unchanged. A digit is accepted on the cycle the counter reaches STABLE_CYCLES. Only one acceptance happens per continuous hold. val_r at that cycle is the captured nibble, and later value changes within the same hold are ignored.
- States:
  - IDLE: waiting for digit 0. Acceptance of digit 0 stores the nibble, sets digits_seen[0] and moves to CAPTURE with expect = 1. Acceptance of digits 1–3 is ignored, with no error.
  - CAPTURE: acceptance of digit == expect stores the nibble, sets its digits_seen bit and increments expect.
    - Accepting digit 3 publishes: count <= {nib3,nib2,nib1,nib0}, valid = 1, digits_seen <= 0, state IDLE.
  - Digit 0 accepted while in CAPTURE (scan restarted early): frame_err pulses, the frame restarts with the new nibble 0, digits_seen = 0001 and expect = 1.
  - Any other out-of-order digit: frame_err pulses, digits_seen <= 0, state IDLE.
- A multi-hot select in any state pulses frame_err (one pulse per distinct multi-hot sel_r value), clears digits_seen and forces IDLE. count never changes on an error.
- Back-to-back frames are supported: the digit 0 following a publish starts the next frame with no gap cycle.

## Timing
- Reset (asynchronous assert, synchronous release edge): count = 0, valid = 0, frame_err = 0, digits_seen = 0, state IDLE, sel_r = blanking, val_r = 0, stability counter = 0.
- Reset asserted mid-frame discards the partial frame. After release, a fresh digit 0 is required.
- Latency: a digit presented on the pins before edge k is registered at edge k and accepted at edge k + STABLE_CYCLES. digits_seen, count/valid (for digit 3) and frame_err are visible after that edge.
  - With STABLE_CYCLES = 1, count and valid change 2 edges after digit 3 appears on the pins.
- valid and frame_err are each high for exactly one cycle per event and are never high in the same cycle.
- A select change that lasts fewer than STABLE_CYCLES samples is never accepted and never raises an error unless it is multi-hot.

## Test plan
- Nominal scan, STABLE_CYCLES = 1, each digit held 4 cycles: 1110/3, 1101/C, 1011/5, 0111/A.
  - Expect count = 16'hA5C3 and valid high for 1 cycle, 2 edges after 0111 first appears.
  - digits_seen steps 0001, 0011, 0111, then 0000.
- Blanking (1111) for 2 cycles between every digit of a frame for 16'h1234 -> count = 16'h1234 with a single valid pulse and no frame_err.
- Order violations:
  - Digit 0 followed by digit 2 -> frame_err pulse, digits_seen = 0, count unchanged.
  - Select 1100 -> frame_err pulse.
  - 0, 1, 0, 1, 2, 3 -> one frame_err pulse at the second digit 0, then valid with the second frame's value.
- Reset low for 3 cycles after digits 0 and 1 of a frame -> all outputs 0 during and after reset.
  - A following digits 1, 2, 3 -> no valid.
  - A following full frame -> valid.
- STABLE_CYCLES = 3:
  - A 1-cycle digit-1 glitch inside digit-0 hold -> not accepted, no error.
  - A digit_value change during a hold -> the first stable sample is kept.
- Continuous driver loopback: driver counts 0x0000..0x0100 with no gaps -> each valid carries a value ≥ the previous one, and there is zero frame_err over the run.
